// File: rtl/mult_div_seq_pkg.sv
// Shared constants for the sequential MULTU/DIVU unit.
//   - st_t      : controller state encoding
//   - OP_MULTU / OP_DIVU : op input encoding
//   - ITER      : iteration counter load value (32 RUN cycles, counting 31..0)
package mult_div_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } st_t;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    localparam int ITER = 31;

endpackage

// File: rtl/mult_div_seq_addsub.sv
// full_adder_subtractor32: the single arithmetic element of the MULTU/DIVU unit.
//   sum  = a_in + (b_in ^ {WIDTH{sub_en}}) + cin
//   cout = carry out of the top bit (for subtract: 1 means no borrow)
// Ports:
//   a_in, b_in : operands
//   sub_en     : invert b_in
//   cin        : carry in (driven equal to sub_en by the controller)
//   sum, cout  : result and carry out
module full_adder_subtractor32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_en,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_b_eff;

    assign w_b_eff     = b_in ^ {WIDTH{sub_en}};
    assign {cout, sum} = {1'b0, a_in} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: multi-cycle unsigned 32x32 MULTU / DIVU for the execute stage.
// One shared adder/subtractor does shift-add multiply and restoring divide,
// one bit per RUN cycle (32 cycles), then a single FIN cycle pulses done.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start, op  : launch (sampled only in IDLE); 0 = MULTU, 1 = DIVU
//   a, b       : multiplicand/dividend, multiplier/divisor
//   hi, lo     : product[63:32]/remainder, product[31:0]/quotient
//   busy       : high while not IDLE
//   done       : one-cycle pulse when hi/lo are valid
//   div_zero   : DIVU with b==0 seen; held until the next accepted start
module mult_div_seq
    import mult_div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    st_t              r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;

    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_add_a;
    logic             w_sub;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Divide shifts the next dividend bit into the partial remainder first;
    // the bit shifted out of hi (msb) is the 33rd remainder bit.
    assign w_rem   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    assign w_sub   = (r_op == OP_DIVU);
    assign w_add_a = w_sub ? w_rem : r_hi;

    full_adder_subtractor32 #(.WIDTH(WIDTH)) u_addsub (
        .a_in   (w_add_a),
        .b_in   (r_m),
        .sub_en (w_sub),
        .cin    (w_sub),
        .sum    (w_sum),
        .cout   (w_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MULTU;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op   <= op;
                        r_m    <= b;
                        r_busy <= 1'b1;
                        if (op == OP_DIVU && b == '0) begin
                            // No iterations: remainder = dividend, quotient all ones.
                            r_hi    <= a;
                            r_lo    <= '1;
                            r_dz    <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end else begin
                            r_hi    <= '0;
                            r_lo    <= a;
                            r_dz    <= 1'b0;
                            r_cnt   <= CNT_W'(ITER);
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (r_op == OP_MULTU) begin
                        // Add multiplicand into upper half when the current
                        // multiplier bit is set, then shift the pair right.
                        if (r_lo[0])
                            {r_hi, r_lo} <= {w_cout, w_sum, r_lo[WIDTH-1:1]};
                        else
                            {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
                    end else begin
                        // Restoring step: subtract if the 33-bit remainder >= m.
                        if (r_hi[WIDTH-1] | w_cout) begin
                            r_hi <= w_sum;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                        end
                    end
                    if (r_cnt == '0) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_FIN: begin
                    // start here is deliberately ignored.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;

endmodule
